// File: rtl/score_display_scanner.sv
// Pong score front end: saturates both scores, converts them with a shared double-dabble engine,
// and scans "P1 xx P2 yy" across eight anodes. Optional `SCORE_BLINK_EN adds winner blinking.
module score_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int MAX_SCORE   = 99
`ifdef SCORE_BLINK_EN
    ,
    parameter int WIN_SCORE   = 7,
    parameter int BLINK_DIV   = 25_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] score_l,
    input  logic [6:0] score_r,
    input  logic       score_valid,
    output logic       busy,
    output logic [7:0] anode,
    output logic [3:0] digit
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  iter;
    logic [14:0] sh;
    logic [14:0] step;
    logic [7:0]  bcd_l;
    logic [6:0]  cap_r;
    logic [6:0]  pend_l, pend_r;
    logic        pend;
    logic        load_in, load_pend, commit;
    logic [3:0]  tens_l, units_l, tens_r, units_r;
    logic [CNT_W-1:0] cnt;
    logic [2:0]  idx;
    logic [3:0]  pos_code;

    function automatic logic [6:0] sat(input logic [6:0] s);
        if (int'(s) > MAX_SCORE) return 7'(MAX_SCORE);
        return s;
    endfunction

    // One double-dabble iteration: BCD nibbles live in [14:7], binary in [6:0].
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    function automatic logic [3:0] blank_zero(input logic [3:0] t);
        return (t == 4'd0) ? 4'hF : t;
    endfunction

    assign step = dd_step(sh);

    always_comb begin
        state_d   = state_q;
        load_in   = 1'b0;
        load_pend = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: if (score_valid) begin
                state_d = CONV_L;
                load_in = 1'b1;
            end
            CONV_L: if (iter == 3'd6) state_d = CONV_R;
            CONV_R: if (iter == 3'd6) state_d = COMMIT;
            COMMIT: begin
                // A newer request supersedes this result, so the display is left untouched.
                if (score_valid) begin
                    state_d = CONV_L;
                    load_in = 1'b1;
                end else if (pend) begin
                    state_d   = CONV_L;
                    load_pend = 1'b1;
                end else begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SCORE_BLINK_EN
    logic [6:0] cap_l, sc_l, sc_r;
    logic [$clog2(BLINK_DIV+1)-1:0] blink_cnt;
    logic       blink;
    logic       hide_l, hide_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
            cap_l     <= '0;
            sc_l      <= '0;
            sc_r      <= '0;
        end else begin
            if (int'(blink_cnt) == BLINK_DIV - 1) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            if (load_in)   cap_l <= sat(score_l);
            if (load_pend) cap_l <= pend_l;
            if (commit) begin
                sc_l <= cap_l;
                sc_r <= cap_r;
            end
        end
    end

    assign hide_l = blink && (int'(sc_l) >= WIN_SCORE);
    assign hide_r = blink && (int'(sc_r) >= WIN_SCORE);
`else
    logic hide_l, hide_r;
    assign hide_l = 1'b0;
    assign hide_r = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            iter    <= '0;
            sh      <= '0;
            bcd_l   <= '0;
            cap_r   <= '0;
            pend    <= 1'b0;
            pend_l  <= '0;
            pend_r  <= '0;
            tens_l  <= 4'hF;
            units_l <= 4'h0;
            tens_r  <= 4'hF;
            units_r <= 4'h0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);

            if (load_in || load_pend) begin
                pend <= 1'b0;
            end else if (score_valid && state_q != IDLE) begin
                pend   <= 1'b1;
                pend_l <= sat(score_l);
                pend_r <= sat(score_r);
            end

            if (load_in) begin
                sh    <= {8'd0, sat(score_l)};
                cap_r <= sat(score_r);
                iter  <= '0;
            end else if (load_pend) begin
                sh    <= {8'd0, pend_l};
                cap_r <= pend_r;
                iter  <= '0;
            end else if (state_q == CONV_L) begin
                if (iter == 3'd6) begin
                    bcd_l <= step[14:7];
                    sh    <= {8'd0, cap_r};
                    iter  <= '0;
                end else begin
                    sh   <= step;
                    iter <= iter + 3'd1;
                end
            end else if (state_q == CONV_R) begin
                sh   <= step;
                iter <= (iter == 3'd6) ? 3'd0 : iter + 3'd1;
            end

            if (commit) begin
                tens_l  <= blank_zero(bcd_l[7:4]);
                units_l <= bcd_l[3:0];
                tens_r  <= blank_zero(sh[14:11]);
                units_r <= sh[10:7];
            end
        end
    end

    always_comb begin
        pos_code = 4'hF;
        case (idx)
            3'd7: pos_code = 4'hB;
            3'd6: pos_code = 4'h1;
            3'd5: pos_code = hide_l ? 4'hF : tens_l;
            3'd4: pos_code = hide_l ? 4'hF : units_l;
            3'd3: pos_code = 4'hB;
            3'd2: pos_code = 4'h2;
            3'd1: pos_code = hide_r ? 4'hF : tens_r;
            3'd0: pos_code = hide_r ? 4'hF : units_r;
            default: pos_code = 4'hF;
        endcase
    end

    // Anode and code are loaded together from idx so they always describe the same position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            anode <= 8'hFF;
            digit <= 4'hF;
        end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt   <= '0;
            idx   <= idx + 3'd1;
            anode <= ~(8'd1 << idx);
            digit <= pos_code;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_score_display_scanner.sv
// Directed bench for score_display_scanner with a fast scan (REFRESH_DIV=4).
module tb_score_display_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] score_l, score_r;
    logic       score_valid;
    logic       busy;
    logic [7:0] anode;
    logic [3:0] digit;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic seen13 = 1'b0;

    score_display_scanner #(.REFRESH_DIV(4), .MAX_SCORE(99)) dut (
        .clk(clk), .rst_n(rst_n), .score_l(score_l), .score_r(score_r),
        .score_valid(score_valid), .busy(busy), .anode(anode), .digit(digit)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (mon_en && ((anode == 8'hDF && digit == 4'h1) || (anode == 8'hEF && digit == 4'h3)))
            seen13 = 1'b1;

    typedef struct {
        logic [6:0]  l;
        logic [6:0]  r;
        logic [31:0] disp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Digits on idx 7..0 packed as one nibble each, idx 7 in the top nibble.
    task automatic capture(output logic [31:0] got);
        logic [3:0] d [8];
        for (int k = 0; k < 8; k++) d[k] = 4'h0;
        repeat (36) @(negedge clk);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++)
                if (anode == ~(8'd1 << k)) d[k] = digit;
        end
        got = {d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0]};
    endtask

    task automatic strobe(input logic [6:0] l, input logic [6:0] r);
        @(negedge clk);
        score_l = l;
        score_r = r;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    vec_t vecs [6];
    logic [31:0] got;
    int n;

    initial begin
        vecs[0] = '{7'd42,  7'd7,  32'hB142B2F7};
        vecs[1] = '{7'd120, 7'd99, 32'hB199B299};
        vecs[2] = '{7'd0,   7'd0,  32'hB1F0B2F0};
        vecs[3] = '{7'd99,  7'd10, 32'hB199B210};
        vecs[4] = '{7'd9,   7'd50, 32'hB1F9B250};
        vecs[5] = '{7'd127, 7'd5,  32'hB199B2F5};

        rst_n = 1'b0;
        score_l = '0;
        score_r = '0;
        score_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_anode", {24'd0, anode}, 32'hFF);
        chk("reset_digit", {28'd0, digit}, 32'hF);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("first_anode", {24'd0, anode}, 32'hFE);
        chk("first_digit", {28'd0, digit}, 32'h0);
        capture(got);
        chk("reset_display", got, 32'hB1F0B2F0);

        for (int i = 0; i < 6; i++) begin
            strobe(vecs[i].l, vecs[i].r);
            count_busy(n);
            chk($sformatf("busy_len_%0d", i), n, 32'd15);
            capture(got);
            chk($sformatf("display_%0d", i), got, vecs[i].disp);
        end

        // Second request during a conversion: busy runs unbroken and only the newest result shows.
        seen13 = 1'b0;
        mon_en = 1'b1;
        strobe(7'd13, 7'd5);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 5) begin
                score_l = 7'd88;
                score_r = 7'd0;
                score_valid = 1'b1;
            end else begin
                score_valid = 1'b0;
            end
            @(negedge clk);
        end
        score_valid = 1'b0;
        chk("pending_busy_len", n, 32'd30);
        capture(got);
        chk("pending_display", got, 32'hB188B2F0);
        mon_en = 1'b0;
        chk("stale_13_shown", {31'd0, seen13}, 32'd0);

        // Reset in the middle of a conversion.
        strobe(7'd55, 7'd55);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_anode", {24'd0, anode}, 32'hFF);
        chk("abort_digit", {28'd0, digit}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("no_stale_busy", n, 32'd0);
        capture(got);
        chk("abort_display", got, 32'hB1F0B2F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
